// File: rtl/sdram_port_arbiter.sv
// Two-port (read/write) arbiter in front of an SDRAM controller, one command outstanding at a time.
// Define ARB_REFRESH_EN to add the periodic auto-refresh timer with priority over port traffic.
module sdram_port_arbiter #(
  parameter int REFRESH_PERIOD = 390
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [25:0] rd_addr,
  output logic        rd_ack,
  input  logic        wr_req,
  input  logic [25:0] wr_addr,
  output logic        wr_ack,
  output logic        mc_valid,
  output logic        mc_write,
  output logic        mc_refresh,
  output logic [25:0] mc_addr,
  input  logic        mc_ready,
  input  logic        mc_done,
  output logic        refresh_miss
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic        last_wr_reg, last_wr_next;
  logic        cmd_write_reg, cmd_write_next;
  logic        cmd_refresh_reg, cmd_refresh_next;
  logic [25:0] addr_reg, addr_next;
  logic        rd_ack_reg, rd_ack_next;
  logic        wr_ack_reg, wr_ack_next;
  logic        refresh_pending;
  logic        refresh_accept;
  logic        rd_ok, wr_ok;

  // A port whose ack is on the wire this cycle still shows its old request; skip it.
  assign rd_ok = rd_req & ~rd_ack_reg;
  assign wr_ok = wr_req & ~wr_ack_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_wr_reg     <= 1'b1;
      cmd_write_reg   <= 1'b0;
      cmd_refresh_reg <= 1'b0;
      addr_reg        <= '0;
      rd_ack_reg      <= 1'b0;
      wr_ack_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_wr_reg     <= last_wr_next;
      cmd_write_reg   <= cmd_write_next;
      cmd_refresh_reg <= cmd_refresh_next;
      addr_reg        <= addr_next;
      rd_ack_reg      <= rd_ack_next;
      wr_ack_reg      <= wr_ack_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_wr_next     = last_wr_reg;
    cmd_write_next   = cmd_write_reg;
    cmd_refresh_next = cmd_refresh_reg;
    addr_next        = addr_reg;
    rd_ack_next      = 1'b0;
    wr_ack_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (refresh_pending) begin
          cmd_refresh_next = 1'b1;
          cmd_write_next   = 1'b0;
          addr_next        = '0;
          state_next       = ISSUE;
        end else if (rd_ok && (!wr_ok || last_wr_reg)) begin
          cmd_refresh_next = 1'b0;
          cmd_write_next   = 1'b0;
          addr_next        = rd_addr;
          last_wr_next     = 1'b0;
          state_next       = ISSUE;
        end else if (wr_ok) begin
          cmd_refresh_next = 1'b0;
          cmd_write_next   = 1'b1;
          addr_next        = wr_addr;
          last_wr_next     = 1'b1;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        if (mc_ready) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mc_done) begin
          rd_ack_next = ~cmd_write_reg & ~cmd_refresh_reg;
          wr_ack_next = cmd_write_reg & ~cmd_refresh_reg;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ARB_REFRESH_EN
  localparam int CNT_W = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_PERIOD - 1);

  logic [CNT_W-1:0] refresh_cnt_reg;
  logic             pending_reg;
  logic             miss_reg;
  logic             cnt_expire;

  assign cnt_expire     = (refresh_cnt_reg == '0);
  assign refresh_accept = (state_reg == ISSUE) & mc_ready & cmd_refresh_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt_reg <= CNT_RELOAD;
      pending_reg     <= 1'b0;
      miss_reg        <= 1'b0;
    end else begin
      refresh_cnt_reg <= cnt_expire ? CNT_RELOAD : refresh_cnt_reg - 1'b1;
      // An expiry that lands on the accepting cycle starts a fresh pending refresh, not a miss.
      miss_reg        <= cnt_expire & pending_reg & ~refresh_accept;
      pending_reg     <= cnt_expire | (pending_reg & ~refresh_accept);
    end
  end

  assign refresh_pending = pending_reg;
  assign refresh_miss    = miss_reg;
`else
  if (REFRESH_PERIOD < 2) begin : g_period_unused
  end
  assign refresh_accept  = 1'b0;
  assign refresh_pending = 1'b0;
  assign refresh_miss    = 1'b0;
`endif

  assign mc_valid   = (state_reg == ISSUE);
  assign mc_write   = mc_valid & cmd_write_reg;
  assign mc_refresh = mc_valid & cmd_refresh_reg;
  assign mc_addr    = addr_reg;
  assign rd_ack     = rd_ack_reg;
  assign wr_ack     = wr_ack_reg;

endmodule
